// File: rtl/irl_pkg.sv
// Shared definitions for the ingress rate limiter refill scheduler.
package irl_pkg;

  // Default widths for the limiter memories.
  localparam int IRL_DEPTH_NBITS   = 4;
  localparam int IRL_LIMITER_NBITS = 3;
  localparam int IRL_PROFILE_NBITS = 24;
  localparam int IRL_FILL_NBITS    = 8;
  localparam int IRL_CIR_TB_NBITS  = 12;
  localparam int IRL_EIR_TB_NBITS  = 12;
  localparam int IRL_INTV_NBITS    = 16;

  // Each memory access is split into an issue state and a wait-for-ack state.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_SRC  = 3'd1,
    S_WT_SRC  = 3'd2,
    S_RD_PROF = 3'd3,
    S_WT_PROF = 3'd4,
    S_RD_TB   = 3'd5,
    S_WT_TB   = 3'd6,
    S_WR_TB   = 3'd7
  } sched_state_e;

endpackage

// File: rtl/irl_refill_sched_sat_add.sv
// Saturating token add: min(cur + inc, burst), never lowering a value
// that already sits above the burst cap.
module irl_tb_sat_add #(
  parameter int TOK_NBITS   = 12,
  parameter int INC_NBITS   = 12,
  parameter int BURST_NBITS = 12
) (
  input  logic [TOK_NBITS-1:0]   cur_i,
  input  logic [INC_NBITS-1:0]   inc_i,
  input  logic [BURST_NBITS-1:0] burst_i,
  output logic [TOK_NBITS-1:0]   res_o
);

  logic [TOK_NBITS-1:0] inc_w;
  logic [TOK_NBITS-1:0] burst_w;
  logic [TOK_NBITS:0]   sum_w;

  // Profile fields are fitted (zero-extend or truncate) to the token width.
  assign inc_w   = TOK_NBITS'(inc_i);
  assign burst_w = TOK_NBITS'(burst_i);
  assign sum_w   = {1'b0, cur_i} + {1'b0, inc_w};

  // Clamp the one-bit-wider sum to the burst cap; hold values already over it.
  always_comb begin
    res_o = cur_i;
    if (cur_i <= burst_w) begin
      res_o = (sum_w > {1'b0, burst_w}) ? burst_w : sum_w[TOK_NBITS-1:0];
    end
  end

endmodule

// File: rtl/irl_refill_sched.sv
// Token-bucket refill scheduler: on each interval tick walks flows
// 0..cfg_last_flow and refills CIR/EIR tokens by read-modify-write,
// yielding the shared bucket ports to the packet path at all times.
module irl_refill_sched
  import irl_pkg::*;
#(
  parameter int DEPTH_NBITS   = IRL_DEPTH_NBITS,
  parameter int LIMITER_NBITS = IRL_LIMITER_NBITS,
  parameter int PROFILE_NBITS = IRL_PROFILE_NBITS,
  parameter int FILL_NBITS    = IRL_FILL_NBITS,
  parameter int CIR_TB_NBITS  = IRL_CIR_TB_NBITS,
  parameter int EIR_TB_NBITS  = IRL_EIR_TB_NBITS,
  parameter int INTV_NBITS    = IRL_INTV_NBITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_en_i,
  input  logic [INTV_NBITS-1:0]                cfg_interval_i,
  input  logic [DEPTH_NBITS-1:0]               cfg_last_flow_i,
  input  logic                                 pkt_tb_rd_i,
  input  logic [DEPTH_NBITS-1:0]               pkt_tb_raddr_i,
  input  logic                                 pkt_tb_wr_i,
  input  logic [DEPTH_NBITS-1:0]               pkt_tb_waddr_i,
  input  logic [CIR_TB_NBITS+EIR_TB_NBITS-1:0] pkt_tb_wdata_i,
  output logic                                 fill_tb_src_rd_o,
  output logic [DEPTH_NBITS-1:0]               fill_tb_src_raddr_o,
  input  logic                                 fill_tb_src_ack_i,
  input  logic [FILL_NBITS-1:0]                fill_tb_src_rdata_i,
  output logic                                 limiting_profile_cir_rd_o,
  output logic [LIMITER_NBITS-1:0]             limiting_profile_cir_raddr_o,
  input  logic                                 limiting_profile_cir_ack_i,
  input  logic [PROFILE_NBITS-1:0]             limiting_profile_cir_rdata_i,
  output logic                                 limiting_profile_eir_rd_o,
  output logic [LIMITER_NBITS-1:0]             limiting_profile_eir_raddr_o,
  input  logic                                 limiting_profile_eir_ack_i,
  input  logic [PROFILE_NBITS-1:0]             limiting_profile_eir_rdata_i,
  output logic                                 token_bucket_rd_o,
  output logic [DEPTH_NBITS-1:0]               token_bucket_raddr_o,
  input  logic                                 token_bucket_ack_i,
  input  logic [CIR_TB_NBITS+EIR_TB_NBITS-1:0] token_bucket_rdata_i,
  output logic                                 token_bucket_wr_o,
  output logic [DEPTH_NBITS-1:0]               token_bucket_waddr_o,
  output logic [CIR_TB_NBITS+EIR_TB_NBITS-1:0] token_bucket_wdata_o,
  output logic                                 busy_o,
  output logic                                 pass_done_o,
  output logic                                 overrun_o
);

  localparam int TB_NBITS    = CIR_TB_NBITS + EIR_TB_NBITS;
  localparam int INC_NBITS   = PROFILE_NBITS / 2;
  localparam int BURST_NBITS = PROFILE_NBITS - INC_NBITS;

  sched_state_e             state_q, state_d;
  logic [DEPTH_NBITS-1:0]   flow_q, flow_d;
  logic [LIMITER_NBITS-1:0] lim_q, lim_d;
  logic [PROFILE_NBITS-1:0] cir_prof_q, cir_prof_d, eir_prof_q, eir_prof_d;
  logic                     cir_seen_q, cir_seen_d, eir_seen_q, eir_seen_d;
  logic [TB_NBITS-1:0]      tb_data_q, tb_data_d;
  logic                     hazard_q, hazard_d;
  logic                     pass_done_q, pass_done_d;
  logic                     owner_q;
  logic [INTV_NBITS-1:0]    cnt_q;
  logic                     overrun_q;

  logic                     tick;
  logic                     pkt_hit;
  logic                     sched_rd;
  logic                     sched_wr;
  logic [CIR_TB_NBITS-1:0]  new_cir;
  logic [EIR_TB_NBITS-1:0]  new_eir;
  logic                     unused_src_bits;

  // Only the limiter id bits of the source word are meaningful.
  assign unused_src_bits = ^fill_tb_src_rdata_i;

  assign tick     = cfg_en_i && (cnt_q == cfg_interval_i);
  assign busy_o   = (state_q != S_IDLE);
  assign pkt_hit  = pkt_tb_wr_i && (pkt_tb_waddr_i == flow_q);
  assign sched_rd = (state_q == S_RD_TB) && !pkt_tb_rd_i;
  assign sched_wr = (state_q == S_WR_TB) && !pkt_tb_wr_i;

  irl_tb_sat_add #(
    .TOK_NBITS(CIR_TB_NBITS), .INC_NBITS(INC_NBITS), .BURST_NBITS(BURST_NBITS)
  ) u_cir_add (
    .cur_i  (tb_data_q[TB_NBITS-1:EIR_TB_NBITS]),
    .inc_i  (cir_prof_q[INC_NBITS-1:0]),
    .burst_i(cir_prof_q[PROFILE_NBITS-1:INC_NBITS]),
    .res_o  (new_cir)
  );

  irl_tb_sat_add #(
    .TOK_NBITS(EIR_TB_NBITS), .INC_NBITS(INC_NBITS), .BURST_NBITS(BURST_NBITS)
  ) u_eir_add (
    .cur_i  (tb_data_q[EIR_TB_NBITS-1:0]),
    .inc_i  (eir_prof_q[INC_NBITS-1:0]),
    .burst_i(eir_prof_q[PROFILE_NBITS-1:INC_NBITS]),
    .res_o  (new_eir)
  );

  // Interval counter and sticky overrun; both cleared while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else if (!cfg_en_i) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick && busy_o) overrun_q <= 1'b1;
    end
  end

  // Scheduler state registers; owner_q marks a bucket read issued by us last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flow_q      <= '0;
      lim_q       <= '0;
      cir_prof_q  <= '0;
      eir_prof_q  <= '0;
      cir_seen_q  <= 1'b0;
      eir_seen_q  <= 1'b0;
      tb_data_q   <= '0;
      hazard_q    <= 1'b0;
      pass_done_q <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      lim_q       <= lim_d;
      cir_prof_q  <= cir_prof_d;
      eir_prof_q  <= eir_prof_d;
      cir_seen_q  <= cir_seen_d;
      eir_seen_q  <= eir_seen_d;
      tb_data_q   <= tb_data_d;
      hazard_q    <= hazard_d;
      pass_done_q <= pass_done_d;
      owner_q     <= sched_rd;
    end
  end

  // Next-state logic. Disabling aborts before the bucket read returns;
  // once bucket data is in hand the write is allowed to finish.
  always_comb begin
    state_d     = state_q;
    flow_d      = flow_q;
    lim_d       = lim_q;
    cir_prof_d  = cir_prof_q;
    eir_prof_d  = eir_prof_q;
    cir_seen_d  = cir_seen_q;
    eir_seen_d  = eir_seen_q;
    tb_data_d   = tb_data_q;
    hazard_d    = hazard_q;
    pass_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          flow_d  = '0;
          state_d = S_RD_SRC;
        end
      end
      S_RD_SRC: state_d = cfg_en_i ? S_WT_SRC : S_IDLE;
      S_WT_SRC: begin
        if (!cfg_en_i) begin
          state_d = S_IDLE;
        end else if (fill_tb_src_ack_i) begin
          lim_d   = fill_tb_src_rdata_i[LIMITER_NBITS-1:0];
          state_d = S_RD_PROF;
        end
      end
      S_RD_PROF: begin
        cir_seen_d = 1'b0;
        eir_seen_d = 1'b0;
        state_d    = cfg_en_i ? S_WT_PROF : S_IDLE;
      end
      S_WT_PROF: begin
        if (limiting_profile_cir_ack_i) begin
          cir_seen_d = 1'b1;
          cir_prof_d = limiting_profile_cir_rdata_i;
        end
        if (limiting_profile_eir_ack_i) begin
          eir_seen_d = 1'b1;
          eir_prof_d = limiting_profile_eir_rdata_i;
        end
        if (!cfg_en_i) begin
          state_d = S_IDLE;
        end else if ((cir_seen_q || limiting_profile_cir_ack_i) &&
                     (eir_seen_q || limiting_profile_eir_ack_i)) begin
          state_d = S_RD_TB;
        end
      end
      S_RD_TB: begin
        if (!cfg_en_i) begin
          state_d = S_IDLE;
        end else if (!pkt_tb_rd_i) begin
          hazard_d = pkt_hit;
          state_d  = S_WT_TB;
        end
      end
      S_WT_TB: begin
        if (token_bucket_ack_i && owner_q && !(hazard_q || pkt_hit)) begin
          tb_data_d = token_bucket_rdata_i;
          state_d   = S_WR_TB;
        end else begin
          // Stale data or missing ack: read the bucket again.
          state_d = cfg_en_i ? S_RD_TB : S_IDLE;
        end
      end
      S_WR_TB: begin
        if (pkt_tb_wr_i) begin
          if (pkt_hit) state_d = cfg_en_i ? S_RD_TB : S_IDLE;
        end else if (!cfg_en_i) begin
          state_d = S_IDLE;
        end else if (flow_q == cfg_last_flow_i) begin
          pass_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          flow_d  = flow_q + 1'b1;
          state_d = S_RD_SRC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fill_tb_src_rd_o             = (state_q == S_RD_SRC);
  assign fill_tb_src_raddr_o          = flow_q;
  assign limiting_profile_cir_rd_o    = (state_q == S_RD_PROF);
  assign limiting_profile_cir_raddr_o = lim_q;
  assign limiting_profile_eir_rd_o    = (state_q == S_RD_PROF);
  assign limiting_profile_eir_raddr_o = lim_q;
  assign pass_done_o                  = pass_done_q;
  assign overrun_o                    = overrun_q;

  // Bucket port mux: packet path passes straight through, scheduler fills idle slots.
  always_comb begin
    token_bucket_rd_o    = 1'b0;
    token_bucket_raddr_o = '0;
    token_bucket_wr_o    = 1'b0;
    token_bucket_waddr_o = '0;
    token_bucket_wdata_o = '0;
    if (rst_n) begin
      if (pkt_tb_rd_i) begin
        token_bucket_rd_o    = 1'b1;
        token_bucket_raddr_o = pkt_tb_raddr_i;
      end else if (sched_rd) begin
        token_bucket_rd_o    = 1'b1;
        token_bucket_raddr_o = flow_q;
      end
      if (pkt_tb_wr_i) begin
        token_bucket_wr_o    = 1'b1;
        token_bucket_waddr_o = pkt_tb_waddr_i;
        token_bucket_wdata_o = pkt_tb_wdata_i;
      end else if (sched_wr) begin
        token_bucket_wr_o    = 1'b1;
        token_bucket_waddr_o = flow_q;
        token_bucket_wdata_o = {new_cir, new_eir};
      end
    end
  end

endmodule

// File: tb/tb_irl_refill_sched.sv
// Directed bench for irl_refill_sched with simple 1-cycle memory models.
module tb_irl_refill_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_interval;
  logic [3:0]  cfg_last_flow;
  logic        pkt_tb_rd, pkt_tb_wr;
  logic [3:0]  pkt_tb_raddr, pkt_tb_waddr;
  logic [23:0] pkt_tb_wdata;
  logic        src_rd, src_ack;
  logic [3:0]  src_raddr;
  logic [7:0]  src_rdata;
  logic        cir_rd, cir_ack, eir_rd, eir_ack;
  logic [2:0]  cir_raddr, eir_raddr;
  logic [23:0] cir_rdata, eir_rdata;
  logic        tb_rd, tb_ack, tb_wr;
  logic [3:0]  tb_raddr, tb_waddr;
  logic [23:0] tb_rdata, tb_wdata;
  logic        busy, pass_done, overrun;

  logic [7:0]  src_mem [16];
  logic [23:0] cir_mem [8];
  logic [23:0] eir_mem [8];
  logic [23:0] tb_mem  [16];
  logic [3:0]  wr_addr_log [256];
  logic [23:0] wr_data_log [256];
  int          wr_cnt = 0;
  int          pd_cnt = 0;

  int checks = 0;
  int errors = 0;
  int base;

  always #5 clk = ~clk;

  irl_refill_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_en_i(cfg_en), .cfg_interval_i(cfg_interval), .cfg_last_flow_i(cfg_last_flow),
    .pkt_tb_rd_i(pkt_tb_rd), .pkt_tb_raddr_i(pkt_tb_raddr),
    .pkt_tb_wr_i(pkt_tb_wr), .pkt_tb_waddr_i(pkt_tb_waddr), .pkt_tb_wdata_i(pkt_tb_wdata),
    .fill_tb_src_rd_o(src_rd), .fill_tb_src_raddr_o(src_raddr),
    .fill_tb_src_ack_i(src_ack), .fill_tb_src_rdata_i(src_rdata),
    .limiting_profile_cir_rd_o(cir_rd), .limiting_profile_cir_raddr_o(cir_raddr),
    .limiting_profile_cir_ack_i(cir_ack), .limiting_profile_cir_rdata_i(cir_rdata),
    .limiting_profile_eir_rd_o(eir_rd), .limiting_profile_eir_raddr_o(eir_raddr),
    .limiting_profile_eir_ack_i(eir_ack), .limiting_profile_eir_rdata_i(eir_rdata),
    .token_bucket_rd_o(tb_rd), .token_bucket_raddr_o(tb_raddr),
    .token_bucket_ack_i(tb_ack), .token_bucket_rdata_i(tb_rdata),
    .token_bucket_wr_o(tb_wr), .token_bucket_waddr_o(tb_waddr), .token_bucket_wdata_o(tb_wdata),
    .busy_o(busy), .pass_done_o(pass_done), .overrun_o(overrun)
  );

  // Memory models with one-cycle read latency; logs scheduler-owned writes.
  always @(posedge clk) begin
    src_ack   <= src_rd;
    src_rdata <= src_mem[src_raddr];
    cir_ack   <= cir_rd;
    cir_rdata <= cir_mem[cir_raddr];
    eir_ack   <= eir_rd;
    eir_rdata <= eir_mem[eir_raddr];
    tb_ack    <= tb_rd;
    tb_rdata  <= tb_mem[tb_raddr];
    if (tb_wr) tb_mem[tb_waddr] <= tb_wdata;
    if (tb_wr && !pkt_tb_wr) begin
      wr_addr_log[wr_cnt[7:0]] <= tb_waddr;
      wr_data_log[wr_cnt[7:0]] <= tb_wdata;
      wr_cnt <= wr_cnt + 1;
      $display("[%0t] sched write addr=%0d data=%06h", $time, tb_waddr, tb_wdata);
    end
    if (pass_done) pd_cnt <= pd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pass(input logic [3:0] last, input logic [15:0] intv, input logic [15:0] run_intv);
    int n;
    @(negedge clk);
    cfg_en = 1'b0;
    @(negedge clk);
    cfg_interval  = intv;
    cfg_last_flow = last;
    cfg_en        = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pass_start_busy", {31'd0, busy}, 32'd1);
    cfg_interval = run_intv;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_prof_rd();
    int n;
    n = 0;
    while (cir_rd !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("prof_rd_seen", {31'd0, cir_rd}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_interval = 16'd0; cfg_last_flow = 4'd0;
    pkt_tb_rd = 1'b0; pkt_tb_raddr = 4'd0; pkt_tb_wr = 1'b0; pkt_tb_waddr = 4'd0;
    pkt_tb_wdata = 24'd0;
    for (int i = 0; i < 16; i++) begin
      src_mem[i] = 8'(i);
      tb_mem[i]  = 24'd0;
    end
    for (int i = 0; i < 8; i++) begin
      cir_mem[i] = 24'd0;
      eir_mem[i] = 24'd0;
    end
    cir_mem[0] = {12'd120, 12'd30};  eir_mem[0] = {12'd200, 12'd50};
    cir_mem[1] = {12'd120, 12'd30};  eir_mem[1] = {12'd100, 12'd10};
    cir_mem[2] = {12'd4095, 12'd5};  eir_mem[2] = {12'd1000, 12'd7};
    tb_mem[0] = {12'd100, 12'd180};
    tb_mem[1] = {12'd150, 12'd150};
    tb_mem[2] = {12'd10, 12'd20};
    tb_mem[5] = {12'd7, 12'd8};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pass_done", {31'd0, pass_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_strobes", {27'd0, src_rd, cir_rd, eir_rd, tb_rd, tb_wr}, 32'd0);
    check("rst_addrs", {13'd0, src_raddr, cir_raddr, eir_raddr, tb_raddr, tb_waddr}, 32'd0);
    check("rst_wdata", {8'd0, tb_wdata}, 32'd0);

    // Basic pass: interval 9, flows 0..2, tick on the 10th enabled cycle
    rst_n = 1'b1; cfg_en = 1'b1; cfg_interval = 16'd9; cfg_last_flow = 4'd2;
    base = wr_cnt;
    repeat (9) @(negedge clk);
    check("tick_not_yet", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("tick_busy", {31'd0, busy}, 32'd1);
    check("tick_src_rd", {27'd0, src_rd, src_raddr}, {27'd0, 1'b1, 4'd0});
    cfg_interval = 16'd500;
    wait_idle("pass1_idle");
    check("pass1_done_pulse", {31'd0, pass_done}, 32'd1);
    @(negedge clk);
    check("pass1_done_clear", {31'd0, pass_done}, 32'd0);
    check("pass1_done_count", pd_cnt, 32'd1);
    check("pass1_wr_count", wr_cnt - base, 32'd3);
    check("pass1_addr0", {28'd0, wr_addr_log[base]}, 32'd0);
    check("pass1_addr1", {28'd0, wr_addr_log[base+1]}, 32'd1);
    check("pass1_addr2", {28'd0, wr_addr_log[base+2]}, 32'd2);
    check("pass1_f0_clamp", {8'd0, wr_data_log[base]}, {8'd0, 12'd120, 12'd200});
    check("pass1_f1_hold", {8'd0, wr_data_log[base+1]}, {8'd0, 12'd150, 12'd150});
    check("pass1_f2_add", {8'd0, wr_data_log[base+2]}, {8'd0, 12'd15, 12'd27});
    check("pass1_overrun", {31'd0, overrun}, 32'd0);

    // Packet read holds the scheduler's bucket read for 5 cycles
    tb_mem[0] = {12'd50, 12'd60};
    start_pass(4'd0, 16'd2, 16'd500);
    base = wr_cnt;
    wait_prof_rd();
    @(negedge clk);
    pkt_tb_rd = 1'b1; pkt_tb_raddr = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pktrd_passthru", {27'd0, tb_rd, tb_raddr}, {27'd0, 1'b1, 4'd5});
    end
    pkt_tb_rd = 1'b0; pkt_tb_raddr = 4'd0;
    #1;
    check("pktrd_sched_issue", {27'd0, tb_rd, tb_raddr}, {27'd0, 1'b1, 4'd0});
    wait_idle("pktrd_idle");
    check("pktrd_wr_count", wr_cnt - base, 32'd1);
    check("pktrd_wdata", {8'd0, wr_data_log[base]}, {8'd0, 12'd80, 12'd110});

    // Packet write to the flow under refill, one cycle after our bucket read
    tb_mem[0] = {12'd50, 12'd60};
    start_pass(4'd0, 16'd2, 16'd500);
    base = wr_cnt;
    wait_prof_rd();
    repeat (2) @(negedge clk);
    check("haz_first_read", {27'd0, tb_rd, tb_raddr}, {27'd0, 1'b1, 4'd0});
    @(negedge clk);
    pkt_tb_wr = 1'b1; pkt_tb_waddr = 4'd0; pkt_tb_wdata = {12'd90, 12'd95};
    @(negedge clk);
    pkt_tb_wr = 1'b0; pkt_tb_wdata = 24'd0;
    #1;
    check("haz_reread", {27'd0, tb_rd, tb_raddr}, {27'd0, 1'b1, 4'd0});
    wait_idle("haz_idle");
    check("haz_wr_count", wr_cnt - base, 32'd1);
    check("haz_wdata", {8'd0, wr_data_log[base]}, {8'd0, 12'd120, 12'd145});

    // Overrun with a short interval; disabling lets the in-flight RMW finish
    begin
      int n;
      start_pass(4'd15, 16'd3, 16'd3);
      check("ovr_initial", {31'd0, overrun}, 32'd0);
      repeat (5) @(negedge clk);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      repeat (10) @(negedge clk);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);
      n = 0;
      while (tb_rd !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("ovr_rd_seen", {31'd0, tb_rd}, 32'd1);
      base = wr_cnt;
      @(negedge clk);
      cfg_en = 1'b0;
      @(negedge clk);
      check("ovr_final_write", {31'd0, tb_wr}, 32'd1);
      check("ovr_cleared", {31'd0, overrun}, 32'd0);
      @(negedge clk);
      check("ovr_idle", {31'd0, busy}, 32'd0);
      check("ovr_no_done", {31'd0, pass_done}, 32'd0);
      check("ovr_wr_count", wr_cnt - base, 32'd1);
    end

    // Reset while the bucket write is held off by packet traffic
    start_pass(4'd0, 16'd2, 16'd500);
    wait_prof_rd();
    repeat (3) @(negedge clk);
    pkt_tb_wr = 1'b1; pkt_tb_waddr = 4'd7; pkt_tb_wdata = 24'h123456;
    @(negedge clk);
    check("hold_passthru", {27'd0, tb_wr, tb_waddr}, {27'd0, 1'b1, 4'd7});
    check("hold_busy", {31'd0, busy}, 32'd1);
    base = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("mrst_strobes", {27'd0, src_rd, cir_rd, eir_rd, tb_rd, tb_wr}, 32'd0);
    check("mrst_wr_bus", {4'd0, tb_waddr, tb_wdata}, 32'd0);
    check("mrst_status", {29'd0, busy, pass_done, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; pkt_tb_wr = 1'b0; pkt_tb_waddr = 4'd0; pkt_tb_wdata = 24'd0; cfg_en = 1'b0;
    @(negedge clk);
    check("mrst_idle", {31'd0, busy}, 32'd0);
    check("mrst_no_write", wr_cnt - base, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irl_refill_sched.md
Name: irl_refill_sched

Overview:
- Token-bucket refill scheduler for the ingress rate limiter memories (fill_tb_src, limiting_profile cir/eir, token_bucket).
- On every refill tick it walks flows 0..num_flows. For each flow it:
  - reads the limiter id from fill_tb_src;
  - fetches the CIR and EIR profiles;
  - does a read-modify-write of the flow's token bucket with saturating adds.
- Shares the token_bucket read/write ports with the packet (policing) path. The packet path always wins.

Parameters:
- DEPTH_NBITS, `FLOW_VALUE_DEPTH_NBITS, flow index width.
- LIMITER_NBITS, `LIMITER_NBITS, limiter/profile index width.
- PROFILE_NBITS, `LIMITING_PROFILE_NBITS, profile word width. Upper half is burst cap; lower half is per-tick increment.
- FILL_NBITS, `FILL_TB_NBITS, fill_tb_src word width. Bits [LIMITER_NBITS-1:0] hold the limiter id.
- CIR_TB_NBITS, `CIR_NBITS+2, CIR token field width.
- EIR_TB_NBITS, `EIR_NBITS+2, EIR token field width.
- INTV_NBITS, 16, refill interval counter width.

Ports:
- clk  in  1  core clock.
- `RESET_SIG  in  1  asynchronous, active-low reset.
- cfg_en  in  1  refill enable.
- cfg_interval  in  INTV_NBITS  clocks between ticks, minus 1.
- cfg_last_flow  in  DEPTH_NBITS  highest flow index to refill.
- pkt_tb_rd  in  1  packet-path token_bucket read.
- pkt_tb_raddr  in  DEPTH_NBITS  packet-path read address.
- pkt_tb_wr  in  1  packet-path token_bucket write.
- pkt_tb_waddr  in  DEPTH_NBITS  packet-path write address.
- pkt_tb_wdata  in  CIR_TB_NBITS+EIR_TB_NBITS  packet-path write data.
- fill_tb_src_rd / fill_tb_src_raddr  out  1 / DEPTH_NBITS  source read.
- fill_tb_src_ack / fill_tb_src_rdata  in  1 / FILL_NBITS  source return.
- limiting_profile_cir_rd / _raddr  out  1 / LIMITER_NBITS  CIR profile read.
- limiting_profile_cir_ack / _rdata  in  1 / PROFILE_NBITS  CIR profile return.
- limiting_profile_eir_rd / _raddr  out  1 / LIMITER_NBITS  EIR profile read.
- limiting_profile_eir_ack / _rdata  in  1 / PROFILE_NBITS  EIR profile return.
- token_bucket_rd / _raddr  out  1 / DEPTH_NBITS  muxed bucket read.
- token_bucket_ack / _rdata  in  1 / CIR_TB_NBITS+EIR_TB_NBITS  bucket return. CIR field is in the MSBs.
- token_bucket_wr / _waddr / _wdata  out  1 / DEPTH_NBITS / CIR_TB_NBITS+EIR_TB_NBITS  muxed bucket write.
- busy  out  1  refill pass in progress.
- pass_done  out  1  one-cycle pulse when a pass completes.
- overrun  out  1  sticky: a tick arrived while busy. Cleared only when cfg_en=0.

Behaviour:
- Reset values:
  - All rd/wr strobes, busy, pass_done and overrun are 0.
  - Addresses and wdata are 0.
  - Interval counter is 0; FSM is IDLE.
- Tick generation:
  - Counter counts up while cfg_en=1. A tick fires when count==cfg_interval, and the counter wraps to 0 on the same cycle.
  - cfg_en=0 clears the counter and overrun, and returns the FSM to IDLE after any in-flight write completes. No partial bucket write is ever dropped mid-RMW.
- FSM per flow (flow index f):
  - IDLE: on tick, set f=0, busy=1, go to RD_SRC.
  - RD_SRC: pulse fill_tb_src_rd(f). Wait for ack; latch the limiter id.
  - RD_PROF: pulse the cir and eir profile reads in the same cycle. Wait until both acks are seen; acks may arrive in different cycles.
  - RD_TB: issue token_bucket_rd(f) only in a cycle with pkt_tb_rd=0; otherwise hold. Wait for ack.
  - WR_TB: issue the write only in a cycle with pkt_tb_wr=0; otherwise hold. Then:
    - if f==cfg_last_flow: pulse pass_done, clear busy, go to IDLE;
    - else f+1, go to RD_SRC.
- Packet-path priority: pkt_tb_* pass through combinationally with zero added latency. The scheduler never inserts a bubble into the packet path.
- Read attribution: a token_bucket_ack belongs to the scheduler only if the scheduler owned the read the previous cycle. A 1-deep owner flag is required.
- RMW hazard: if pkt_tb_wr with pkt_tb_waddr==f occurs from the scheduler's bucket-read issue up to and including its write cycle, the scheduler discards its data and re-enters RD_TB. There is no retry limit.
- Arithmetic:
  - new_cir = min(cir + cir_inc, cir_burst), computed at CIR_TB_NBITS+1 bits and then clamped.
  - EIR is identical, using the eir profile.
  - Burst/increment fields are zero-extended or truncated to the token field width.
  - An existing value already above burst is held, never decreased.
- Overrun: a tick while busy sets overrun. That tick is dropped, not queued.
- Reset mid-pass: the FSM aborts immediately. Buckets partially refilled in that pass are not rolled back.

Decomposition:
- Shared package (irl_pkg / defines.vh): FSM state encoding, profile field split macros (burst hi / inc lo), token-bucket field slice macros.
- One natural sub-module: irl_tb_sat_add, a combinational saturating add-and-clamp instantiated twice (CIR, EIR).

Test Plan:
- cfg_interval=9, cfg_last_flow=2, no packet traffic → tick at cycle 10; three writes to addresses 0,1,2; pass_done pulses once; busy is low afterward.
- Bucket cir=100, inc=30, burst=120 → written cir=120. Bucket cir=150, burst=120 → cir stays 150. Same cases checked on the EIR field.
- pkt_tb_rd held high for 5 cycles during RD_TB → scheduler read is delayed 5 cycles; the packet acks are not consumed by the scheduler; the scheduler's bucket write is still correct.
- pkt_tb_wr to the flow under refill one cycle after the scheduler's bucket read → scheduler re-reads; final value = packet value + inc (clamped).
- cfg_interval=3 with cfg_last_flow large → overrun sets on the next tick and stays set; cfg_en=0 clears it; FSM reaches IDLE after the in-flight write.
- Assert `RESET_SIG low during WR_TB hold → all outputs 0 that cycle; no write issued; IDLE after release.
